// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the EX stage (requester 0) and the aux
// address/branch unit (requester 1): registered issue stage S1, response stage S2.
module alu_share_arbiter #(
    parameter int PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x,
    input  logic [31:0] req0_y,
    input  logic [2:0]  req0_op,
    input  logic [5:0]  req0_shamt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x,
    input  logic [31:0] req1_y,
    input  logic [2:0]  req1_op,
    input  logic [5:0]  req1_shamt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_out,
    output logic [31:0] rsp_nflag,
    output logic [31:0] flag0,
    output logic [31:0] flag1,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    output logic [2:0]  alu_op,
    output logic [5:0]  alu_shamt,
    output logic [31:0] alu_flag,
    input  logic [31:0] alu_out,
    input  logic [31:0] alu_nflag
);

    logic        s1_valid;
    logic        s1_id;
    logic [31:0] s1_x;
    logic [31:0] s1_y;
    logic [2:0]  s1_op;
    logic [5:0]  s1_shamt;

    logic        s2_valid;
    logic        s2_id;
    logic [31:0] s2_out;
    logic [31:0] s2_nflag;

    logic [31:0] flag0_q;
    logic [31:0] flag1_q;
    logic        last_grant;

    logic        s2_free;
    logic        s1_move;
    logic        s1_free;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        accept_id;

    assign s2_free = ~s2_valid | rsp_ready;
    assign s1_move = s1_valid & s2_free;
    assign s1_free = ~s1_valid | s1_move;

    // On contention, round-robin favours whoever did not win last time.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (PRIORITY == 1 || last_grant) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = rst_n & s1_free & grant0;
    assign req1_ready = rst_n & s1_free & grant1;
    assign accept     = req0_ready | req1_ready;
    assign accept_id  = req1_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_id      <= 1'b0;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_op      <= '0;
            s1_shamt   <= '0;
            s2_valid   <= 1'b0;
            s2_id      <= 1'b0;
            s2_out     <= '0;
            s2_nflag   <= '0;
            flag0_q    <= '0;
            flag1_q    <= '0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                s1_id      <= accept_id;
                s1_x       <= accept_id ? req1_x     : req0_x;
                s1_y       <= accept_id ? req1_y     : req0_y;
                s1_op      <= accept_id ? req1_op    : req0_op;
                s1_shamt   <= accept_id ? req1_shamt : req0_shamt;
                last_grant <= accept_id;
            end

            if (accept) begin
                s1_valid <= 1'b1;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end

            // Flag context commits as the op leaves S1, so a back-to-back op
            // from the same requester already sees the new value.
            if (s1_move) begin
                s2_id    <= s1_id;
                s2_out   <= alu_out;
                s2_nflag <= alu_nflag;
                if (s1_id) begin
                    flag1_q <= alu_nflag;
                end else begin
                    flag0_q <= alu_nflag;
                end
            end

            if (s1_move) begin
                s2_valid <= 1'b1;
            end else if (rsp_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign alu_x     = s1_x;
    assign alu_y     = s1_y;
    assign alu_op    = s1_op;
    assign alu_shamt = s1_shamt;
    assign alu_flag  = s1_id ? flag1_q : flag0_q;

    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_id;
    assign rsp_out   = s2_out;
    assign rsp_nflag = s2_nflag;
    assign flag0     = flag0_q;
    assign flag1     = flag1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: round-robin instance checked against a response
// scoreboard, plus a fixed-priority instance for the priority scenario.
module tb_alu_share_arbiter;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_LESS = 3'd4;
    localparam logic [2:0] OP_B    = 3'd5;
    localparam logic [2:0] OP_SAR  = 3'd6;

    typedef struct {
        logic        id;
        logic [31:0] out;
        logic [31:0] nflag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        fp_req0_valid = 1'b0, fp_req1_valid = 1'b0;
    logic [31:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [5:0]  req0_shamt = '0, req1_shamt = '0;
    logic        rsp_ready = 1'b0, fp_rsp_ready = 1'b1;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [31:0] rsp_out, rsp_nflag, flag0, flag1, alu_x, alu_y, alu_flag, alu_out, alu_nflag;
    logic [2:0]  alu_op;
    logic [5:0]  alu_shamt;

    logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id;
    logic [31:0] fp_rsp_out, fp_rsp_nflag, fp_flag0, fp_flag1, fp_alu_x, fp_alu_y, fp_alu_flag;
    logic [31:0] fp_alu_out, fp_alu_nflag;
    logic [2:0]  fp_alu_op;
    logic [5:0]  fp_alu_shamt;

    always #5 clk = ~clk;

    // Stand-in ALU: nflag bit0 = signed overflow, bit1 = zero result.
    function automatic logic [63:0] alu_model(input logic [2:0] op, input logic [31:0] x,
                                              input logic [31:0] y, input logic [5:0] sh);
        logic [31:0] r;
        logic        ov;
        r  = '0;
        ov = 1'b0;
        case (op)
            OP_ADD:  begin r = x + y; ov = (x[31] == y[31]) && (r[31] != x[31]); end
            OP_SUB:  begin r = x - y; ov = (x[31] != y[31]) && (r[31] != x[31]); end
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_LESS: r = {31'b0, ($signed(x) < $signed(y))};
            OP_B:    r = y;
            OP_SAR:  r = $unsigned($signed(y) >>> x[4:0]);
            default: r = x << sh[4:0];
        endcase
        return {30'b0, (r == 32'd0), ov, r};
    endfunction

    assign {alu_nflag, alu_out}       = alu_model(alu_op, alu_x, alu_y, alu_shamt);
    assign {fp_alu_nflag, fp_alu_out} = alu_model(fp_alu_op, fp_alu_x, fp_alu_y, fp_alu_shamt);

    alu_share_arbiter #(.PRIORITY(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req0_op(req0_op), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .req1_op(req1_op), .req1_shamt(req1_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .rsp_nflag(rsp_nflag), .flag0(flag0), .flag1(flag1),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_shamt(alu_shamt),
        .alu_flag(alu_flag), .alu_out(alu_out), .alu_nflag(alu_nflag)
    );

    alu_share_arbiter #(.PRIORITY(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req0_op(req0_op), .req0_shamt(req0_shamt),
        .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .req1_op(req1_op), .req1_shamt(req1_shamt),
        .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_id(fp_rsp_id), .rsp_out(fp_rsp_out),
        .rsp_nflag(fp_rsp_nflag), .flag0(fp_flag0), .flag1(fp_flag1),
        .alu_x(fp_alu_x), .alu_y(fp_alu_y), .alu_op(fp_alu_op), .alu_shamt(fp_alu_shamt),
        .alu_flag(fp_alu_flag), .alu_out(fp_alu_out), .alu_nflag(fp_alu_nflag)
    );

    // Response side of the scoreboard: every transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d out=%h nflag=%h, required no response",
                         rsp_id, rsp_out, rsp_nflag);
            end else begin
                e = sb_q.pop_front();
                if (rsp_id !== e.id || rsp_out !== e.out || rsp_nflag !== e.nflag) begin
                    errors++;
                    $display("FAIL rsp_data: got id=%0d out=%h nflag=%h, required id=%0d out=%h nflag=%h",
                             rsp_id, rsp_out, rsp_nflag, e.id, e.out, e.nflag);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic [31:0] out, input logic [31:0] nflag);
        exp_t e;
        e.id    = id;
        e.out   = out;
        e.nflag = nflag;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        fp_req0_valid = 1'b0;
        fp_req1_valid = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b, required 00", req0_ready, req1_ready);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_out, rsp_nflag, flag0, flag1} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b out=%h nflag=%h f0=%h f1=%h, required all 0",
                     rsp_valid, rsp_out, rsp_nflag, flag0, flag1);
        end
        checks++;
        if ({alu_x, alu_y, alu_op, alu_shamt, alu_flag} !== '0) begin
            errors++;
            $display("FAIL reset_alu: got x=%h y=%h op=%0d sh=%0d flag=%h, required all 0",
                     alu_x, alu_y, alu_op, alu_shamt, alu_flag);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = OP_SUB; req0_x = 32'd300; req0_y = 32'd300; req0_shamt = '0;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: got ready=%b, required 1", req0_ready);
        end
        push(1'b0, 32'd0, 32'd2);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || alu_op !== OP_SUB || alu_x !== 32'd300 || alu_flag !== 32'd0) begin
            errors++;
            $display("FAIL single_issue: got v=%b op=%0d x=%0d flag=%h, required v=0 op=1 x=300 flag=0",
                     rsp_valid, alu_op, alu_x, alu_flag);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || flag0 !== 32'd2) begin
            errors++;
            $display("FAIL single_latency: got v=%b flag0=%h, required v=1 flag0=2", rsp_valid, flag0);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || flag1 !== 32'd0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL single_drain: got v=%b flag1=%h pending=%0d, required v=0 flag1=0 pending=0",
                     rsp_valid, flag1, sb_q.size());
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic exp0;
        do_reset();
        rsp_ready = 1'b1;
        req0_op = OP_ADD; req0_x = 32'd100; req0_y = 32'd200;
        req1_op = OP_ADD; req1_x = 32'h7fff_ffff; req1_y = 32'd1; req1_shamt = '0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp0 = (i % 2 == 0);
            checks++;
            if (req0_ready !== exp0 || req1_ready !== !exp0) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got ready=%b%b, required %b%b",
                         i, req1_ready, req0_ready, !exp0, exp0);
            end
            if (exp0) push(1'b0, 32'd300, 32'd0);
            else      push(1'b1, 32'h8000_0000, 32'd1);
            if (i >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_throughput[%0d]: got rsp_valid=%b, required 1", i, rsp_valid);
                end
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_tail[%0d]: got rsp_valid=%b, required 1", i, rsp_valid);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL rr_drain: got v=%b pending=%0d, required v=0 pending=0", rsp_valid, sb_q.size());
        end
        tick();
    endtask

    task automatic test_back_pressure();
        logic [2:0]  ops     [4] = '{OP_AND, OP_OR, OP_LESS, OP_B};
        logic [31:0] exp_out [4] = '{32'h40, 32'hEC, 32'd1, 32'd200};
        logic        rdy_exp [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        rr_tab  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int j = 0;
        for (int c = 0; c < 6; c++) begin
            rsp_ready = rr_tab[c];
            req0_valid = 1'b1; req0_op = ops[j]; req0_x = 32'd100; req0_y = 32'd200;
            @(negedge clk);
            checks++;
            if (req0_ready !== rdy_exp[c]) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b, required %b", c, req0_ready, rdy_exp[c]);
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_out !== 32'h40) begin
                    errors++;
                    $display("FAIL bp_hold[%0d]: got v=%b out=%h, required v=1 out=40", c, rsp_valid, rsp_out);
                end
            end
            if (rdy_exp[c]) begin
                push(1'b0, exp_out[j], 32'd0);
                j++;
            end
            tick();
        end
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got pending=%0d v=%b, required pending=0 v=0", sb_q.size(), rsp_valid);
        end
        tick();
    endtask

    task automatic test_flag_isolation();
        do_reset();
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_x = 32'h7fff_ffff; req0_y = 32'd1;
        @(negedge clk);
        push(1'b0, 32'h8000_0000, 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = OP_SAR; req1_x = 32'hF11; req1_y = 32'h8234_5678; req1_shamt = '0;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1 || alu_x !== 32'h7fff_ffff || alu_flag !== 32'd0) begin
            errors++;
            $display("FAIL iso_first: got ready1=%b x=%h flag=%h, required 1 7fffffff 0",
                     req1_ready, alu_x, alu_flag);
        end
        push(1'b1, 32'hffff_c11a, 32'd0);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_op !== OP_SAR || alu_y !== 32'h8234_5678 || alu_flag !== 32'd0 || flag0 !== 32'd1) begin
            errors++;
            $display("FAIL iso_flag1: got op=%0d y=%h alu_flag=%h flag0=%h, required 6 82345678 0 1",
                     alu_op, alu_y, alu_flag, flag0);
        end
        tick();
        @(negedge clk);
        checks++;
        if (flag0 !== 32'd1 || flag1 !== 32'd0) begin
            errors++;
            $display("FAIL iso_final: got flag0=%h flag1=%h, required 1 0", flag0, flag1);
        end
        tick();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL iso_drain: got pending=%0d, required 0", sb_q.size());
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        fp_rsp_ready = 1'b1;
        req0_op = OP_ADD; req0_x = 32'd1; req0_y = 32'd2;
        req1_op = OP_ADD; req1_x = 32'd3; req1_y = 32'd4;
        fp_req0_valid = 1'b1;
        fp_req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (fp_req0_ready !== 1'b1 || fp_req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL fp_grant[%0d]: got ready=%b%b, required 01", i, fp_req1_ready, fp_req0_ready);
            end
            tick();
        end
        fp_req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (fp_req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL fp_req1_grant: got %b, required 1", fp_req1_ready);
        end
        tick();
        fp_req1_valid = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (fp_rsp_valid !== 1'b1 || fp_rsp_id !== 1'b1 || fp_rsp_out !== 32'd7) begin
            errors++;
            $display("FAIL fp_rsp: got v=%b id=%b out=%h, required 1 1 7", fp_rsp_valid, fp_rsp_id, fp_rsp_out);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_x = 32'h7fff_ffff; req0_y = 32'd1;
        tick();
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || flag0 !== 32'd1) begin
            errors++;
            $display("FAIL mid_setup: got v=%b flag0=%h, required 1 1", rsp_valid, flag0);
        end
        tick();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_ready_in_reset: got %b%b, required 00", req1_ready, req0_ready);
        end
        tick();
        sb_q.delete();
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, flag0, flag1} !== '0 || {alu_x, alu_y, alu_op, alu_shamt, alu_flag} !== '0) begin
            errors++;
            $display("FAIL mid_cleared: got v=%b f0=%h f1=%h x=%h y=%h op=%0d flag=%h, required all 0",
                     rsp_valid, flag0, flag1, alu_x, alu_y, alu_op, alu_flag);
        end
        tick();
        rsp_ready = 1'b1;
        repeat (2) tick();
        req0_op = OP_ADD; req0_x = 32'd100; req0_y = 32'd200;
        req1_op = OP_ADD; req1_x = 32'h7fff_ffff; req1_y = 32'd1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_first_grant: got ready=%b%b, required 01", req1_ready, req0_ready);
        end
        push(1'b0, 32'd300, 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL mid_drain: got pending=%0d, required 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_back_pressure();
        test_flag_isolation();
        test_fixed_priority();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
